// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// muldiv_unit : RV32M execute-stage unit, 1-cycle multiply, 32-step divider
// Revision    : 1.0
// ============================================================================
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DIV_ITER = 2'd1,
    S_DIV_FIX  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [XLEN-1:0]   rem_q, rem_d;
  logic [XLEN-1:0]   quo_q, quo_d;
  logic [XLEN-1:0]   dvsr_q, dvsr_d;
  logic              neg_q_q, neg_q_d;
  logic              neg_r_q, neg_r_d;
  logic              rem_sel_q, rem_sel_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              done_q, done_d;

  // Multiply: sign-extend to 2*XLEN so a plain modular product is exact.
  logic              w_mul_a_signed, w_mul_b_signed;
  logic [2*XLEN-1:0] w_mul_a, w_mul_b, w_prod;
  logic [XLEN-1:0]   w_mul_res;

  logic              w_div_signed, w_a_neg, w_b_neg, w_div_zero, w_div_ovf;
  logic [XLEN-1:0]   w_a_mag, w_b_mag;
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic [XLEN-1:0]   w_quo_fix, w_rem_fix;

  always_comb begin
    w_mul_a_signed = ~(funct3[1] & funct3[0]);
    w_mul_b_signed = ~funct3[1];
    w_mul_a   = {{XLEN{w_mul_a_signed & rs1_val[XLEN-1]}}, rs1_val};
    w_mul_b   = {{XLEN{w_mul_b_signed & rs2_val[XLEN-1]}}, rs2_val};
    w_prod    = w_mul_a * w_mul_b;
    w_mul_res = (funct3[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    w_div_signed = ~funct3[0];
    w_a_neg      = w_div_signed & rs1_val[XLEN-1];
    w_b_neg      = w_div_signed & rs2_val[XLEN-1];
    w_a_mag      = w_a_neg ? (~rs1_val + 1'b1) : rs1_val;
    w_b_mag      = w_b_neg ? (~rs2_val + 1'b1) : rs2_val;
    w_div_zero   = (rs2_val == '0);
    w_div_ovf    = w_div_signed && (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);

    // Restoring step on the 33-bit shifted partial remainder.
    w_rem_sh  = {rem_q, quo_q[XLEN-1]};
    w_diff    = w_rem_sh - {1'b0, dvsr_q};

    w_quo_fix = neg_q_q ? (~quo_q + 1'b1) : quo_q;
    w_rem_fix = neg_r_q ? (~rem_q + 1'b1) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    rem_sel_d = rem_sel_q;
    result_d  = result_q;
    done_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          if (!funct3[2]) begin
            result_d = w_mul_res;
            done_d   = 1'b1;
          end else if (w_div_zero) begin
            result_d = funct3[1] ? rs1_val : '1;
            done_d   = 1'b1;
          end else if (w_div_ovf) begin
            result_d = funct3[1] ? '0 : rs1_val;
            done_d   = 1'b1;
          end else begin
            state_d   = S_DIV_ITER;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = w_a_mag;
            dvsr_d    = w_b_mag;
            neg_q_d   = w_a_neg ^ w_b_neg;
            neg_r_d   = w_a_neg;
            rem_sel_d = funct3[1];
          end
        end
      end
      S_DIV_ITER: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          if (!w_diff[XLEN]) begin
            rem_d = w_diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = w_rem_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) state_d = S_DIV_FIX;
        end
      end
      S_DIV_FIX: begin
        state_d = S_IDLE;
        if (!flush) begin
          result_d = rem_sel_q ? w_rem_fix : w_quo_fix;
          done_d   = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      rem_sel_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      rem_sel_q <= rem_sel_d;
      result_q  <= result_d;
      done_q    <= done_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// tb_muldiv_unit : directed scoreboard bench for muldiv_unit
// Revision       : 1.0
// ============================================================================
module tb_muldiv_unit;

  localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
  localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
  localparam int DIV_LAT = 34;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] rs1_val, rs2_val;
  logic        flush;
  logic        busy, done;
  logic [31:0] result;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .flush(flush),
    .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] val;
    int          cyc;
  } exp_t;
  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got result %h with no op outstanding (cycle %0d)", result, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_result", result, e.val);
        chk("done_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    start   = 1'b1;
    funct3  = f;
    rs1_val = a;
    rs2_val = b;
    if (push) begin
      sb.push_back('{exp, cyc + lat});
      last_res = exp;
    end
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 100) begin
      step();
      n++;
    end
    if (busy) chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    int n;
    rst = 1'b1; start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; flush = 1'b0;
    step(); step();
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    rst = 1'b0;
    step();

    // Single-cycle ops back to back; busy must stay low.
    issue(MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1, 1'b1);
    chk("mul_busy", 32'(busy), 32'd0);
    issue(MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 1'b1);
    issue(MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1'b1);
    issue(MUL,    32'd7,         32'd6,         32'h0000_002A, 1, 1'b1);
    chk("mul_busy2", 32'(busy), 32'd0);
    issue(DIVU,   32'd5,         32'd0,         32'hFFFF_FFFF, 1, 1'b1);
    chk("dz_busy", 32'(busy), 32'd0);
    issue(REMU,   32'd5,         32'd0,         32'd5,         1, 1'b1);
    issue(DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b1);
    chk("ovf_busy", 32'(busy), 32'd0);
    issue(REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 1'b1);
    chk("ovf_busy2", 32'(busy), 32'd0);
    step();

    // Signed divide with busy-window check, then MUL issued in the done cycle.
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, DIV_LAT, 1'b1);
    busy_cnt = 0;
    for (int i = 1; i <= 33; i++) begin
      if (busy) busy_cnt++;
      step();
    end
    chk("div_busy_cycles", 32'(busy_cnt), 32'd33);
    chk("div_busy_at_done", 32'(busy), 32'd0);
    issue(MUL, 32'd3, 32'd3, 32'h0000_0009, 1, 1'b1);
    step();

    issue(REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, DIV_LAT, 1'b1); wait_idle("rem");
    issue(DIVU, 32'd100,       32'd7,         32'd14,        DIV_LAT, 1'b1); wait_idle("divu");
    issue(REMU, 32'd100,       32'd7,         32'd2,         DIV_LAT, 1'b1); wait_idle("remu");
    issue(DIV,  32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, DIV_LAT, 1'b1); wait_idle("div_negb");
    issue(REM,  32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFFE, DIV_LAT, 1'b1); wait_idle("rem_nega");
    step();

    // Operand isolation and an ignored start at k+5.
    issue(DIVU, 32'd1000, 32'd10, 32'd100, DIV_LAT, 1'b1);
    for (int i = 1; i <= 33; i++) begin
      rs1_val = $urandom;
      rs2_val = $urandom;
      funct3  = MUL;
      start   = (i == 5);
      step();
    end
    start = 1'b0;
    step(); step();

    // Flush at k+10: no done, result held, then a MUL right away.
    issue(DIV, 32'hFFFF_FFF9, 32'd2, 32'd0, DIV_LAT, 1'b0);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_result_held", result, last_res);
    issue(MUL, 32'd5, 32'd9, 32'd45, 1, 1'b1);
    repeat (40) step();

    // Reset at k+20 of a divide, then a MUL right away.
    issue(DIVU, 32'd1000, 32'd3, 32'd0, DIV_LAT, 1'b0);
    repeat (19) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_res = '0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    issue(MUL, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1, 1'b1);
    repeat (40) step();

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
